// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the regfile_sb register file slice.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writer scoreboard: one bit per register, set on issue, cleared on writeback,
// wiped on flush or bulk clear, with combinational lookups for every read port.
module regfile_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_all_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        rd_pend_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] sb_q;
    logic [DEPTH-1:0] sb_d;

    // Per-entry next state; issue outranks writeback so a fresh writer stays pending.
    always_comb begin
        sb_d = sb_q;
        if (clear_all_i) begin
            sb_d = {DEPTH{1'b0}};
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (iss_en_i && (iss_addr_i == ADDR_W'(e))) begin
                    sb_d[e] = 1'b1;
                end else if (wr_en_i && (wr_addr_i == ADDR_W'(e))) begin
                    sb_d[e] = 1'b0;
                end else begin
                    sb_d[e] = sb_q[e];
                end
            end
        end
        sb_d[0] = sb_d[0] & ~ZERO_REG;
    end

    // Scoreboard state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_q <= {DEPTH{1'b0}};
        end else begin
            sb_q <= sb_d;
        end
    end

    // Read-port lookups.
    always_comb begin
        rd_pend_o = {NUM_RD{1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
            rd_pend_o[i] = sb_q[rd_addr_i[i*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-through bypass, RAW scoreboard and a sequential bulk-clear engine.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    input  logic                     flush_i,
    input  logic                     clr_req_i,
    output logic                     clr_busy_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    clr_state_e        state_q;
    clr_state_e        state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic              in_clear_s;
    logic              wr_ok_s;
    logic              iss_ok_s;
    logic [NUM_RD-1:0] pend_s;
    logic [ADDR_W-1:0] ra_s;
    logic              byp_s;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == {ADDR_W{1'b0}});
    endfunction

    assign in_clear_s = (state_q == ST_CLEAR);
    assign wr_ok_s    = wr_en_i && !in_clear_s && !is_zero_reg(wr_addr_i);
    assign iss_ok_s   = iss_en_i && !in_clear_s && !is_zero_reg(iss_addr_i);
    assign clr_busy_o = in_clear_s;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_all_i (flush_i || in_clear_s),
        .iss_en_i    (iss_ok_s),
        .iss_addr_i  (iss_addr_i),
        .wr_en_i     (wr_ok_s),
        .wr_addr_i   (wr_addr_i),
        .rd_addr_i   (rd_addr_i),
        .rd_pend_o   (pend_s)
    );

    // Bulk-clear FSM next state; idx wraps to 0 on the final step as the FSM leaves CLEAR.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req_i) begin
                    state_d = ST_CLEAR;
                    idx_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                    idx_d   = idx_q;
                end
            end
            ST_CLEAR: begin
                idx_d = idx_q + ADDR_W'(1'b1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // FSM state and clear index registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Storage array: the clear engine owns the write port while active.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= {DATA_W{1'b0}};
            end
        end else if (in_clear_s) begin
            mem_q[idx_q] <= {DATA_W{1'b0}};
        end else if (wr_ok_s) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read ports; bypass is held off during reset so outputs stay zero while rst_ni is low.
    always_comb begin
        rd_data_o = {(NUM_RD*DATA_W){1'b0}};
        rd_busy_o = {NUM_RD{1'b0}};
        ra_s      = {ADDR_W{1'b0}};
        byp_s     = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra_s  = rd_addr_i[i*ADDR_W +: ADDR_W];
            byp_s = rst_ni && wr_ok_s && (wr_addr_i == ra_s);
            if (is_zero_reg(ra_s)) begin
                rd_data_o[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rd_busy_o[i]                  = 1'b0;
            end else if (byp_s) begin
                rd_data_o[i*DATA_W +: DATA_W] = wr_data_i;
                rd_busy_o[i]                  = 1'b0;
            end else begin
                rd_data_o[i*DATA_W +: DATA_W] = mem_q[ra_s];
                rd_busy_o[i]                  = pend_s[i] && !in_clear_s;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: per-cycle vector table plus clear and reset-during-clear sequences.
module tb_regfile_sb;

    logic        clk_i;
    logic        rst_ni;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_o;
    logic [1:0]  rd_busy_o;
    logic        wr_en_i;
    logic [4:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic        iss_en_i;
    logic [4:0]  iss_addr_i;
    logic        flush_i;
    logic        clr_req_i;
    logic        clr_busy_o;

    int errors = 0;
    int checks = 0;

    regfile_sb dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_busy_o  (rd_busy_o),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .flush_i    (flush_i),
        .clr_req_i  (clr_req_i),
        .clr_busy_o (clr_busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ia, input logic fl,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.fl = fl;
        v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1; v.eb = eb;
        return v;
    endfunction

    function automatic logic [31:0] fill_val(input int i);
        return 32'hA000_0000 | (32'(i) * 32'h0001_0001);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en_i    = 1'b0;
        wr_addr_i  = 5'd0;
        wr_data_i  = 32'd0;
        iss_en_i   = 1'b0;
        iss_addr_i = 5'd0;
        flush_i    = 1'b0;
        clr_req_i  = 1'b0;
        rd_addr_i  = 10'd0;
    endtask

    // Reads every register over 16 cycles and returns how many were non-zero or busy.
    task automatic scan_all(output int nz, output int bz);
        nz = 0;
        bz = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk_i);
            idle();
            rd_addr_i = {5'(2*j + 1), 5'(2*j)};
            #4;
            if (rd_data_o[31:0] != 32'd0) nz++;
            if (rd_data_o[63:32] != 32'd0) nz++;
            if (rd_busy_o != 2'b00) bz++;
        end
    endtask

    initial begin
        int busy_cnt;
        int bad_busy;
        int nz;
        int bz;
        int n;

        vecs[0]  = mk(0, 0,  32'h0,        0, 0,  0, 5,  0,  32'h0,        32'h0,        2'b00);
        vecs[1]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0, 1,  2,  32'h0,        32'h0,        2'b00);
        vecs[2]  = mk(0, 0,  32'h0,        0, 0,  0, 5,  0,  32'hDEADBEEF, 32'h0,        2'b00);
        vecs[3]  = mk(1, 0,  32'h00001234, 0, 0,  0, 0,  5,  32'h0,        32'hDEADBEEF, 2'b00);
        vecs[4]  = mk(0, 0,  32'h0,        0, 0,  0, 0,  0,  32'h0,        32'h0,        2'b00);
        vecs[5]  = mk(1, 7,  32'hA5A5A5A5, 0, 0,  0, 5,  7,  32'hDEADBEEF, 32'hA5A5A5A5, 2'b00);
        vecs[6]  = mk(0, 0,  32'h0,        1, 3,  0, 3,  7,  32'h0,        32'hA5A5A5A5, 2'b00);
        vecs[7]  = mk(0, 0,  32'h0,        0, 0,  0, 3,  7,  32'h0,        32'hA5A5A5A5, 2'b01);
        vecs[8]  = mk(1, 3,  32'h11111111, 0, 0,  0, 3,  9,  32'h11111111, 32'h0,        2'b00);
        vecs[9]  = mk(0, 0,  32'h0,        0, 0,  0, 3,  3,  32'h11111111, 32'h11111111, 2'b00);
        vecs[10] = mk(1, 3,  32'h22222222, 1, 3,  0, 3,  4,  32'h22222222, 32'h0,        2'b00);
        vecs[11] = mk(0, 0,  32'h0,        0, 0,  0, 3,  4,  32'h22222222, 32'h0,        2'b01);
        vecs[12] = mk(1, 3,  32'h33333333, 0, 0,  0, 4,  3,  32'h0,        32'h33333333, 2'b00);
        vecs[13] = mk(0, 0,  32'h0,        1, 9,  0, 3,  9,  32'h33333333, 32'h0,        2'b00);
        vecs[14] = mk(0, 0,  32'h0,        1, 12, 0, 9,  3,  32'h0,        32'h33333333, 2'b01);
        vecs[15] = mk(0, 0,  32'h0,        1, 3,  0, 12, 9,  32'h0,        32'h0,        2'b11);
        vecs[16] = mk(0, 0,  32'h0,        0, 0,  1, 3,  12, 32'h33333333, 32'h0,        2'b11);
        vecs[17] = mk(0, 0,  32'h0,        1, 4,  1, 3,  9,  32'h33333333, 32'h0,        2'b00);
        vecs[18] = mk(0, 0,  32'h0,        0, 0,  0, 4,  12, 32'h0,        32'h0,        2'b00);
        vecs[19] = mk(0, 0,  32'h0,        1, 0,  0, 0,  0,  32'h0,        32'h0,        2'b00);
        vecs[20] = mk(0, 0,  32'h0,        0, 0,  0, 0,  3,  32'h0,        32'h33333333, 2'b00);
        vecs[21] = mk(1, 2,  32'hCAFEF00D, 1, 2,  0, 2,  5,  32'hCAFEF00D, 32'hDEADBEEF, 2'b00);
        vecs[22] = mk(0, 0,  32'h0,        0, 0,  0, 2,  31, 32'hCAFEF00D, 32'h0,        2'b01);

        rst_ni = 1'b0;
        idle();
        wr_en_i   = 1'b1;
        wr_addr_i = 5'd5;
        wr_data_i = 32'h5555AAAA;
        rd_addr_i = {5'd6, 5'd5};
        #1;
        check("reset clr_busy", {31'd0, clr_busy_o}, 32'd0);
        check("reset rd_data0", rd_data_o[31:0], 32'd0);
        check("reset rd_busy", {30'd0, rd_busy_o}, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        idle();
        rst_ni = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk_i);
            wr_en_i    = vecs[i].we;
            wr_addr_i  = vecs[i].wa;
            wr_data_i  = vecs[i].wd;
            iss_en_i   = vecs[i].ie;
            iss_addr_i = vecs[i].ia;
            flush_i    = vecs[i].fl;
            clr_req_i  = 1'b0;
            rd_addr_i  = {vecs[i].a1, vecs[i].a0};
            #4;
            check($sformatf("vec%0d data0", i), rd_data_o[31:0], vecs[i].e0);
            check($sformatf("vec%0d data1", i), rd_data_o[63:32], vecs[i].e1);
            check($sformatf("vec%0d busy", i), {30'd0, rd_busy_o}, {30'd0, vecs[i].eb});
        end

        // Fill every register, then run a bulk clear while hammering the write/issue ports.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk_i);
            idle();
            wr_en_i   = 1'b1;
            wr_addr_i = 5'(i);
            wr_data_i = fill_val(i);
        end
        @(negedge clk_i);
        idle();
        rd_addr_i = {5'd31, 5'd25};
        clr_req_i = 1'b1;
        #4;
        check("fill x25", rd_data_o[31:0], fill_val(25));
        check("fill x31", rd_data_o[63:32], fill_val(31));
        check("clr_busy before start", {31'd0, clr_busy_o}, 32'd0);

        busy_cnt = 0;
        bad_busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            idle();
            wr_en_i    = 1'b1;
            wr_addr_i  = 5'd3;
            wr_data_i  = 32'hFFFFFFFF;
            iss_en_i   = 1'b1;
            iss_addr_i = 5'd3;
            clr_req_i  = 1'b1;
            rd_addr_i  = {5'd25, (busy_cnt == 0) ? 5'd3 : 5'd10};
            #4;
            if (!clr_busy_o) begin
                idle();
                break;
            end
            if (busy_cnt == 0) check("clear no bypass x3", rd_data_o[31:0], fill_val(3));
            if (busy_cnt == 20) begin
                check("mid-clear x10", rd_data_o[31:0], 32'd0);
                check("mid-clear x25", rd_data_o[63:32], fill_val(25));
            end
            if (rd_busy_o != 2'b00) bad_busy++;
            busy_cnt++;
        end
        check("clr_busy cycles", 32'(busy_cnt), 32'd32);
        check("rd_busy during clear", 32'(bad_busy), 32'd0);
        scan_all(nz, bz);
        check("after clear nonzero regs", 32'(nz), 32'd0);
        check("after clear busy regs", 32'(bz), 32'd0);

        // Reset in the middle of a clear.
        @(negedge clk_i);
        idle();
        wr_en_i   = 1'b1;
        wr_addr_i = 5'd20;
        wr_data_i = 32'h12345678;
        @(negedge clk_i);
        idle();
        iss_en_i   = 1'b1;
        iss_addr_i = 5'd8;
        @(negedge clk_i);
        idle();
        clr_req_i = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            idle();
            if (clr_busy_o) n++;
            if (n == 10) begin
                rst_ni    = 1'b0;
                wr_en_i   = 1'b1;
                wr_addr_i = 5'd20;
                wr_data_i = 32'h87654321;
                rd_addr_i = {5'd8, 5'd20};
                #1;
                check("rst mid-clear clr_busy", {31'd0, clr_busy_o}, 32'd0);
                check("rst mid-clear data0", rd_data_o[31:0], 32'd0);
                check("rst mid-clear data1", rd_data_o[63:32], 32'd0);
                check("rst mid-clear busy", {30'd0, rd_busy_o}, 32'd0);
                break;
            end
        end
        check("reached clear cycle 10", 32'(n), 32'd10);
        @(negedge clk_i);
        idle();
        rst_ni = 1'b1;
        #4;
        check("post-reset clr_busy", {31'd0, clr_busy_o}, 32'd0);
        scan_all(nz, bz);
        check("post-reset nonzero regs", 32'(nz), 32'd0);
        check("post-reset busy regs", 32'(bz), 32'd0);

        @(negedge clk_i);
        idle();
        wr_en_i   = 1'b1;
        wr_addr_i = 5'd20;
        wr_data_i = 32'h0BADF00D;
        @(negedge clk_i);
        idle();
        rd_addr_i = {5'd0, 5'd20};
        #4;
        check("post-reset write x20", rd_data_o[31:0], 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
